// File: rtl/pspin_cmd_router.sv
// pspin_cmd_router
//
// Routes HPU commands from N_SRC sources (flat index cluster_id*NUM_CORES+core_id)
// to N_INTF command interfaces (host-direct, NIC outbound, eDMA, ...).
// Each interface has its own round-robin arbiter and a single registered output
// slot. Each source has a credit counter that bounds issued-but-uncompleted
// commands. Interfaces report completions, and completions decrement that counter.
//
// Ports
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   cmd_valid_i       per-source command valid
//   cmd_ready_o       per-source accept (grant or bad-interface drop)
//   cmd_i             per-source payload, source s at [s*CMD_W +: CMD_W]
//   cmd_intf_i        per-source destination interface id
//   intf_valid_o      per-interface output slot valid
//   intf_ready_i      per-interface slot accept
//   intf_cmd_o        per-interface slot payload
//   intf_src_o        per-interface originating source of the slot
//   cmpl_valid_i      per-interface completion pulse (always accepted)
//   cmpl_src_i        per-interface source the completion belongs to
//   outstanding_o     per-source outstanding command count
//   err_bad_intf_o    pulse: a command addressed a nonexistent interface and was dropped
//   err_underflow_o   pulse: a completion arrived for a source with nothing outstanding

module pspin_cmd_router #(
    parameter int N_SRC           = 16,
    parameter int N_INTF          = 3,
    parameter int CMD_W           = 640,
    parameter int MAX_OUTSTANDING = 4,
    parameter int SRC_IDW         = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    parameter int INTF_IDW        = (N_INTF > 1) ? $clog2(N_INTF) : 1,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_SRC-1:0]           cmd_valid_i,
    output logic [N_SRC-1:0]           cmd_ready_o,
    input  logic [N_SRC*CMD_W-1:0]     cmd_i,
    input  logic [N_SRC*INTF_IDW-1:0]  cmd_intf_i,
    output logic [N_INTF-1:0]          intf_valid_o,
    input  logic [N_INTF-1:0]          intf_ready_i,
    output logic [N_INTF*CMD_W-1:0]    intf_cmd_o,
    output logic [N_INTF*SRC_IDW-1:0]  intf_src_o,
    input  logic [N_INTF-1:0]          cmpl_valid_i,
    input  logic [N_INTF*SRC_IDW-1:0]  cmpl_src_i,
    output logic [N_SRC*CNT_W-1:0]     outstanding_o,
    output logic                       err_bad_intf_o,
    output logic                       err_underflow_o
);

    // Packed views of the flat buses.
    logic [N_SRC-1:0][CMD_W-1:0]     src_cmd;
    logic [N_SRC-1:0][INTF_IDW-1:0]  src_intf;
    logic [N_INTF-1:0][SRC_IDW-1:0]  cmpl_src;

    assign src_cmd  = cmd_i;
    assign src_intf = cmd_intf_i;
    assign cmpl_src = cmpl_src_i;

    // State
    logic [N_INTF-1:0]               valid_q, valid_d;
    logic [N_INTF-1:0][CMD_W-1:0]    slot_cmd_q, slot_cmd_d;
    logic [N_INTF-1:0][SRC_IDW-1:0]  slot_src_q, slot_src_d;
    logic [N_INTF-1:0][SRC_IDW-1:0]  ptr_q, ptr_d;
    logic [N_SRC-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic                            err_bad_q, err_bad_d;
    logic                            err_under_q, err_under_d;

    // Per-source qualifiers. Credit is judged on the registered count, so a
    // completion in this cycle only frees credit from the next cycle on.
    logic [N_SRC-1:0] has_credit;
    logic [N_SRC-1:0] bad_intf;
    logic [N_SRC-1:0] src_gnt;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch;
        // a path that leaves a variable unassigned would infer a latch.
        has_credit = '0;
        bad_intf   = '0;
        for (int s = 0; s < N_SRC; s++) begin
            has_credit[s] = int'(cnt_q[s]) < MAX_OUTSTANDING;
            bad_intf[s]   = cmd_valid_i[s] && (int'(src_intf[s]) >= N_INTF);
        end
    end

    // Round-robin arbitration: each interface scans the sources starting at
    // its pointer and grants the first eligible one, but only when its slot
    // can load (empty, or draining this cycle). A source names a single
    // interface, so it can receive at most one grant per cycle.
    always_comb begin
        int idx;
        idx        = 0;
        valid_d    = valid_q;
        slot_cmd_d = slot_cmd_q;
        slot_src_d = slot_src_q;
        ptr_d      = ptr_q;
        src_gnt    = '0;
        for (int i = 0; i < N_INTF; i++) begin
            if (!valid_q[i] || intf_ready_i[i]) begin
                valid_d[i] = 1'b0;
                for (int k = 0; k < N_SRC; k++) begin
                    idx = (int'(ptr_q[i]) + k) % N_SRC;
                    if (!valid_d[i] && cmd_valid_i[idx] && has_credit[idx] &&
                        (src_intf[idx] == INTF_IDW'(i))) begin
                        valid_d[i]    = 1'b1;
                        slot_cmd_d[i] = src_cmd[idx];
                        slot_src_d[i] = SRC_IDW'(idx);
                        ptr_d[i]      = SRC_IDW'((idx + 1) % N_SRC);
                        src_gnt[idx]  = 1'b1;
                    end
                end
            end
        end
    end

    assign cmd_ready_o = src_gnt | bad_intf;
    assign err_bad_d   = |bad_intf;

    // Credit counters: add this cycle's grant, subtract every completion that
    // names the source. Too many completions clamp to zero and flag underflow.
    always_comb begin
        int net;
        net         = 0;
        cnt_d       = cnt_q;
        err_under_d = 1'b0;
        for (int s = 0; s < N_SRC; s++) begin
            net = int'(cnt_q[s]) + int'(src_gnt[s]);
            for (int j = 0; j < N_INTF; j++) begin
                if (cmpl_valid_i[j] && (int'(cmpl_src[j]) == s)) begin
                    net = net - 1;
                end
            end
            if (net < 0) begin
                cnt_d[s]    = '0;
                err_under_d = 1'b1;
            end else begin
                cnt_d[s] = CNT_W'(net);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // NOTE: the wide payload registers are reset as well because
            // intf_cmd_o is observable and must read zero after reset.
            valid_q     <= '0;
            slot_cmd_q  <= '0;
            slot_src_q  <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
            err_bad_q   <= 1'b0;
            err_under_q <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments, so every
            // register samples the pre-edge values computed above.
            valid_q     <= valid_d;
            slot_cmd_q  <= slot_cmd_d;
            slot_src_q  <= slot_src_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            err_bad_q   <= err_bad_d;
            err_under_q <= err_under_d;
        end
    end

    assign intf_valid_o    = valid_q;
    assign intf_cmd_o      = slot_cmd_q;
    assign intf_src_o      = slot_src_q;
    assign outstanding_o   = cnt_q;
    assign err_bad_intf_o  = err_bad_q;
    assign err_underflow_o = err_under_q;

endmodule
